// File: rtl/nf10_axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI4-Stream test packet generator:
// FSM state encoding, default beat geometry and index/remainder widths.
package nf10_axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    localparam int DATA_W = 256;
    localparam int BYTES  = DATA_W / 8;
    localparam int LANES  = DATA_W / 32;
    localparam int BEAT_W = 16;
    localparam int REM_W  = 6;

endpackage

// File: rtl/nf10_axis_pkt_gen_if.sv
// AXI4-Stream bundle: tdata/tstrb/tuser/tvalid/tlast from master,
// tready from slave.
interface nf10_axis_pkt_gen_if #(
    parameter int DW = 256,
    parameter int UW = 128
);

    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic [UW-1:0]   tuser;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    modport master (
        output tdata, tstrb, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tuser, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/nf10_axis_pkt_gen_beat.sv
// Combinational beat formatter: pkt_idx/beat_idx/is_last/rem/pkt_len in,
// tdata/tstrb/tuser out. NF10_AXIS_PKT_GEN_TUSER_META_EN adds tuser meta.
module nf10_axis_pkt_gen_beat
    import nf10_axis_pkt_gen_pkg::*;
#(
    parameter int         DW  = 256,
    parameter int         UW  = 128,
    parameter logic [7:0] SRC = 8'h01
) (
    input  logic [15:0]       pkt_idx,
    input  logic [BEAT_W-1:0] beat_idx,
    input  logic              is_last,
    input  logic [REM_W-1:0]  rem,
    input  logic [15:0]       pkt_len,
    output logic [DW-1:0]     tdata,
    output logic [DW/8-1:0]   tstrb,
    output logic [UW-1:0]     tuser
);

    localparam int NB = DW / 8;
    localparam int NL = DW / 32;

    always_comb begin
        tdata = '0;
        for (int k = 0; k < NL; k++) begin
            tdata[k*32 +: 32] = {pkt_idx, beat_idx[12:0], 3'(k)};
        end
    end

    // Only a partial last beat trims the byte mask.
    always_comb begin
        tstrb = '0;
        for (int i = 0; i < NB; i++) begin
            tstrb[i] = !is_last || (rem == '0) || (i < int'(rem));
        end
    end

    logic unused_hi;
    assign unused_hi = ^beat_idx[BEAT_W-1:13];

`ifdef NF10_AXIS_PKT_GEN_TUSER_META_EN
    always_comb begin
        tuser = '0;
        if (beat_idx == '0) begin
            tuser[15:0]  = pkt_len;
            tuser[23:16] = SRC;
        end
    end
`else
    logic unused_len;
    assign unused_len = ^pkt_len;
    assign tuser      = '0;
`endif

endmodule

// File: rtl/nf10_axis_pkt_gen.sv
// AXI4-Stream packet generator: start/pkt_len/pkt_count/ipg in, m_axis out,
// busy/counter/activity_send status. Macro: NF10_AXIS_PKT_GEN_TUSER_META_EN.
module nf10_axis_pkt_gen
    import nf10_axis_pkt_gen_pkg::*;
#(
    parameter int         C_M_AXIS_DATA_WIDTH  = DATA_W,
    parameter int         C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0] C_SRC_PORT           = 8'h01
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                start,
    input  logic [15:0]         pkt_len,
    input  logic [15:0]         pkt_count,
    input  logic [7:0]          ipg,
    nf10_axis_pkt_gen_if.master m_axis,
    output logic                busy,
    output logic [7:0]          counter,
    output logic                activity_send
);

    localparam int DW = C_M_AXIS_DATA_WIDTH;
    localparam int UW = C_M_AXIS_TUSER_WIDTH;
    localparam int NB = DW / 8;

    state_t            state, state_n;
    logic [15:0]       pkt_idx, pkt_n;
    logic [BEAT_W-1:0] beat_idx, beat_n;
    logic [7:0]        gap_cnt, gap_n;
    logic [15:0]       len_q, count_q;
    logic [7:0]        ipg_q;
    logic [BEAT_W-1:0] last_q;
    logic [REM_W-1:0]  rem_q;

    logic              tvalid_q, valid_n;
    logic              tlast_q;
    logic [DW-1:0]     tdata_q;
    logic [NB-1:0]     tstrb_q;
    logic [UW-1:0]     tuser_q;
    logic              act_n, cnt_inc, load;

    logic [16:0]       in_beats;
    logic [BEAT_W-1:0] in_last, cur_last;
    logic [REM_W-1:0]  in_rem, cur_rem;
    logic [15:0]       cur_len;
    logic              last_n;
    logic [DW-1:0]     f_data;
    logic [NB-1:0]     f_strb;
    logic [UW-1:0]     f_user;

    // Geometry of the packet being launched, derived from the live inputs.
    assign in_beats = (17'(pkt_len) + 17'(NB - 1)) / 17'(NB);
    assign in_last  = BEAT_W'(in_beats - 17'd1);
    assign in_rem   = REM_W'(pkt_len % 16'(NB));

    // In IDLE the beat being loaded belongs to the config on the inputs.
    assign cur_last = (state == IDLE) ? in_last : last_q;
    assign cur_rem  = (state == IDLE) ? in_rem  : rem_q;
    assign cur_len  = (state == IDLE) ? pkt_len : len_q;
    assign last_n   = (beat_n == cur_last);

    nf10_axis_pkt_gen_beat #(
        .DW  (DW),
        .UW  (UW),
        .SRC (C_SRC_PORT)
    ) u_beat (
        .pkt_idx  (pkt_n),
        .beat_idx (beat_n),
        .is_last  (last_n),
        .rem      (cur_rem),
        .pkt_len  (cur_len),
        .tdata    (f_data),
        .tstrb    (f_strb),
        .tuser    (f_user)
    );

    always_comb begin
        state_n = state;
        pkt_n   = pkt_idx;
        beat_n  = beat_idx;
        gap_n   = gap_cnt;
        valid_n = tvalid_q;
        load    = 1'b0;
        act_n   = 1'b0;
        cnt_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && pkt_len != '0 && pkt_count != '0) begin
                    state_n = SEND;
                    pkt_n   = '0;
                    beat_n  = '0;
                    valid_n = 1'b1;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (tvalid_q && m_axis.tready) begin
                    if (beat_idx == last_q) begin
                        act_n   = 1'b1;
                        cnt_inc = 1'b1;
                        pkt_n   = pkt_idx + 16'd1;
                        if (pkt_n == count_q) begin
                            state_n = IDLE;
                            valid_n = 1'b0;
                        end else if (ipg_q != '0) begin
                            state_n = GAP;
                            gap_n   = ipg_q;
                            valid_n = 1'b0;
                        end else begin
                            beat_n = '0;
                            load   = 1'b1;
                        end
                    end else begin
                        beat_n = beat_idx + 1'b1;
                        load   = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 8'd1) begin
                    state_n = SEND;
                    beat_n  = '0;
                    valid_n = 1'b1;
                    load    = 1'b1;
                end else begin
                    gap_n = gap_cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            pkt_idx  <= '0;
            beat_idx <= '0;
            gap_cnt  <= '0;
            len_q    <= '0;
            count_q  <= '0;
            ipg_q    <= '0;
            last_q   <= '0;
            rem_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tuser_q  <= '0;
            busy     <= 1'b0;
            counter  <= '0;
            activity_send <= 1'b0;
        end else begin
            state    <= state_n;
            pkt_idx  <= pkt_n;
            beat_idx <= beat_n;
            gap_cnt  <= gap_n;
            tvalid_q <= valid_n;
            busy     <= (state_n != IDLE);
            activity_send <= act_n;
            if (cnt_inc) counter <= counter + 8'd1;
            if (state == IDLE && state_n == SEND) begin
                len_q   <= pkt_len;
                count_q <= pkt_count;
                ipg_q   <= ipg;
                last_q  <= in_last;
                rem_q   <= in_rem;
            end
            if (load) begin
                tdata_q <= f_data;
                tstrb_q <= f_strb;
                tuser_q <= f_user;
                tlast_q <= last_n;
            end else if (!valid_n) begin
                tlast_q <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tstrb  = tstrb_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Directed bench for nf10_axis_pkt_gen: launches packet runs and checks
// beats, masks, payload lanes, gaps, counter and activity pulses.
module tb_nf10_axis_pkt_gen;

    localparam int DW = 256;
    localparam int UW = 128;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [15:0] pkt_count = '0;
    logic [7:0]  ipg = '0;
    logic        busy;
    logic [7:0]  counter;
    logic        activity_send;

    nf10_axis_pkt_gen_if #(.DW(DW), .UW(UW)) axis ();

    nf10_axis_pkt_gen #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_SRC_PORT           (8'h01)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .pkt_len       (pkt_len),
        .pkt_count     (pkt_count),
        .ipg           (ipg),
        .m_axis        (axis.master),
        .busy          (busy),
        .counter       (counter),
        .activity_send (activity_send)
    );

    always #5 aclk = ~aclk;

    int compared = 0;
    int mismatched = 0;

    logic [255:0] q_data[$];
    logic [31:0]  q_strb[$];
    logic         q_last[$];
    logic [127:0] q_user[$];
    int           gaps[$];
    int           gap_run = 0;
    int           act_cnt = 0;
    int           stall_err = 0;
    logic         stall_prev = 1'b0;
    logic [417:0] snap;

    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
            gap_run = 0;
        end else begin
            if (stall_prev && {axis.tvalid, axis.tdata, axis.tstrb,
                               axis.tuser, axis.tlast} !== snap)
                stall_err++;
            stall_prev = axis.tvalid && !axis.tready;
            snap = {axis.tvalid, axis.tdata, axis.tstrb,
                    axis.tuser, axis.tlast};
            if (axis.tvalid && axis.tready) begin
                q_data.push_back(axis.tdata);
                q_strb.push_back(axis.tstrb);
                q_last.push_back(axis.tlast);
                q_user.push_back(axis.tuser);
            end
            if (busy && !axis.tvalid) begin
                gap_run++;
            end else if (axis.tvalid && gap_run > 0) begin
                gaps.push_back(gap_run);
                gap_run = 0;
            end
            if (activity_send) act_cnt++;
        end
    end

    function automatic logic [255:0] dat(int i);
        return (i < q_data.size()) ? q_data[i] : 'x;
    endfunction
    function automatic logic [31:0] stb(int i);
        return (i < q_strb.size()) ? q_strb[i] : 'x;
    endfunction
    function automatic logic lst(int i);
        return (i < q_last.size()) ? q_last[i] : 1'bx;
    endfunction
    function automatic logic [127:0] usr(int i);
        return (i < q_user.size()) ? q_user[i] : 'x;
    endfunction
    function automatic int gp(int i);
        return (i < gaps.size()) ? gaps[i] : -1;
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_strb.delete();
        q_last.delete();
        q_user.delete();
        gaps.delete();
        gap_run = 0;
        act_cnt = 0;
        stall_err = 0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        clear_mon();
    endtask

    task automatic launch(input logic [15:0] l, input logic [15:0] c,
                          input logic [7:0] g);
        @(posedge aclk);
        #1;
        pkt_len = l;
        pkt_count = c;
        ipg = g;
        start = 1'b1;
        @(posedge aclk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd,
                             input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge aclk);
            #1;
            if (rnd) axis.tready = 1'($urandom_range(0, 1));
            n++;
        end
        chk(tag, busy, 1'b0);
        axis.tready = 1'b1;
        @(negedge aclk);
        #1;
    endtask

    localparam logic [255:0] B0 =
        256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;

    initial begin
        axis.tready = 1'b1;

        // reset state
        #3;
        chk("rst_tvalid", axis.tvalid, 1'b0);
        chk("rst_tlast", axis.tlast, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_act", activity_send, 1'b0);
        chk("rst_counter", counter, 8'd0);
        chk("rst_tdata", axis.tdata, 256'd0);
        chk("rst_tstrb", axis.tstrb, 32'd0);
        chk("rst_tuser", axis.tuser, 128'd0);
        do_reset();

        // 64 bytes, one packet
        launch(16'd64, 16'd1, 8'd0);
        chk("t1_lat_valid", axis.tvalid, 1'b1);
        chk("t1_lat_busy", busy, 1'b1);
        wait_idle(50, 1'b0, "t1_timeout");
        chk("t1_beats", q_data.size(), 2);
        chk("t1_strb0", stb(0), 32'hFFFFFFFF);
        chk("t1_strb1", stb(1), 32'hFFFFFFFF);
        chk("t1_last0", lst(0), 1'b0);
        chk("t1_last1", lst(1), 1'b1);
        chk("t1_data0", dat(0), B0);
        chk("t1_data1_l0", dat(1) & 256'hFFFFFFFF, 256'h8);
        chk("t1_counter", counter, 8'd1);
        chk("t1_act", act_cnt, 1);
        chk("t1_tvalid_end", axis.tvalid, 1'b0);
`ifdef NF10_AXIS_PKT_GEN_TUSER_META_EN
        chk("t1_user0", usr(0), 128'h010040);
`else
        chk("t1_user0", usr(0), 128'h0);
`endif
        chk("t1_user1", usr(1), 128'h0);

        // 33 bytes x3 with ipg 4
        do_reset();
        launch(16'd33, 16'd3, 8'd4);
        wait_idle(100, 1'b0, "t2_timeout");
        chk("t2_beats", q_data.size(), 6);
        chk("t2_strb0", stb(0), 32'hFFFFFFFF);
        chk("t2_strb1", stb(1), 32'h00000001);
        chk("t2_strb3", stb(3), 32'h00000001);
        chk("t2_strb5", stb(5), 32'h00000001);
        chk("t2_last5", lst(5), 1'b1);
        chk("t2_ngaps", gaps.size(), 2);
        chk("t2_gap0", gp(0), 4);
        chk("t2_gap1", gp(1), 4);
        chk("t2_p2b1_l0", dat(5) & 256'hFFFFFFFF, 256'h00020008);
        chk("t2_counter", counter, 8'd3);
        chk("t2_act", act_cnt, 3);

        // 100 bytes x5 with random backpressure
        do_reset();
        axis.tready = 1'b0;
        launch(16'd100, 16'd5, 8'd0);
        wait_idle(400, 1'b1, "t3_timeout");
        chk("t3_beats", q_data.size(), 20);
        chk("t3_stall", stall_err, 0);
        chk("t3_strb19", stb(19), 32'h0000000F);
        chk("t3_last19", lst(19), 1'b1);
        chk("t3_b19_l0", dat(19) & 256'hFFFFFFFF, 256'h00040018);
        chk("t3_counter", counter, 8'd5);
        chk("t3_act", act_cnt, 5);

        // 300 one-byte packets, counter wraps
        do_reset();
        launch(16'd1, 16'd300, 8'd0);
        wait_idle(1000, 1'b0, "t4_timeout");
        chk("t4_beats", q_data.size(), 300);
        chk("t4_strb0", stb(0), 32'h00000001);
        chk("t4_last0", lst(0), 1'b1);
        chk("t4_b299_l0", dat(299) & 256'hFFFFFFFF, 256'h012B0000);
        chk("t4_counter", counter, 8'd44);
        chk("t4_act", act_cnt, 300);

        // zero length ignored, start while busy ignored
        do_reset();
        launch(16'd0, 16'd5, 8'd0);
        repeat (2) @(posedge aclk);
        #1;
        chk("t5_zero_busy", busy, 1'b0);
        chk("t5_zero_valid", axis.tvalid, 1'b0);
        launch(16'd64, 16'd2, 8'd0);
        pkt_len = 16'd1;
        pkt_count = 16'd1;
        ipg = 8'd9;
        start = 1'b1;
        @(posedge aclk);
        #1 start = 1'b0;
        wait_idle(50, 1'b0, "t5_timeout");
        chk("t5_beats", q_data.size(), 4);
        chk("t5_strb3", stb(3), 32'hFFFFFFFF);
        chk("t5_b2_l0", dat(2) & 256'hFFFFFFFF, 256'h00010000);
        chk("t5_ngaps", gaps.size(), 0);
        chk("t5_counter", counter, 8'd2);

        // reset in the middle of beat 1 of a 3-beat packet
        do_reset();
        axis.tready = 1'b0;
        launch(16'd96, 16'd1, 8'd0);
        axis.tready = 1'b1;
        @(posedge aclk);
        #1 axis.tready = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        chk("t6_rst_valid", axis.tvalid, 1'b0);
        chk("t6_rst_counter", counter, 8'd0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_tdata", axis.tdata, 256'd0);
        chk("t6_pre_beats", q_data.size(), 1);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        clear_mon();
        axis.tready = 1'b1;
        launch(16'd64, 16'd1, 8'd0);
        wait_idle(50, 1'b0, "t6_timeout");
        chk("t6_beats", q_data.size(), 2);
        chk("t6_data0", dat(0), B0);
        chk("t6_counter", counter, 8'd1);
`ifdef NF10_AXIS_PKT_GEN_TUSER_META_EN
        chk("t6_user0", usr(0) & 128'hFFFFFF, 128'h010040);
`else
        chk("t6_user0", usr(0), 128'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nf10_axis_pkt_gen.md
# nf10_axis_pkt_gen

AXI4-Stream master that synthesises test packets for the simulation and bring-up harness. It is the transmit-side counterpart of the stream recorders and drives their `s_axis_*` inputs. It emits `pkt_count` packets of `pkt_len` bytes each, with a deterministic, self-checking payload and a programmable inter-packet gap. It exposes a wrapping packet counter and a per-packet activity strobe.

## Interface
- `C_M_AXIS_DATA_WIDTH`, 256: tdata width in bits; multiple of 32, at most 256.
- `C_M_AXIS_TUSER_WIDTH`, 128: tuser width in bits; at least 32.
- `C_SRC_PORT`, 8'h01: source-port code placed in tuser (see Configuration).
- `aclk`  in  1  sole clock; all logic is rising-edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `pkt_len`  in  16  packet length in bytes; sampled with `start`.
- `pkt_count`  in  16  number of packets; sampled with `start`.
- `ipg`  in  8  idle cycles inserted after each packet except the last; sampled with `start`.
- `m_axis_tdata`  out  C_M_AXIS_DATA_WIDTH  beat payload.
- `m_axis_tstrb`  out  C_M_AXIS_DATA_WIDTH/8  byte-valid mask.
- `m_axis_tuser`  out  C_M_AXIS_TUSER_WIDTH  sideband.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  last beat of packet.
- `busy`  out  1  high while not in IDLE.
- `counter`  out  8  packets completed, modulo 256.
- `activity_send`  out  1  one-cycle pulse per accepted tlast beat.

## Operation
- The FSM has three states: IDLE, SEND and GAP.
  - IDLE to SEND: `start`=1 and `pkt_len`≠0 and `pkt_count`≠0. The block latches the config and clears `pkt_idx` and `beat_idx`. When either length is 0, `start` is ignored.
  - SEND: a beat is accepted on `tvalid & tready`, which advances `beat_idx`. Acceptance of the tlast beat increments `pkt_idx` and `counter` and pulses `activity_send`. The next state is then:
    - IDLE if this was the final packet;
    - GAP if `ipg`≠0;
    - otherwise SEND with `beat_idx` cleared.
  - GAP: holds `tvalid`=0 for exactly `ipg` cycles, then goes to SEND.
- Beats per packet = ceil(`pkt_len`/BYTES), where BYTES = C_M_AXIS_DATA_WIDTH/8.
- `tlast` is asserted on beat index beats−1.
- `tstrb` is all ones on non-last beats. On the last beat it has the low (`pkt_len` mod BYTES) bits set, or all ones when the remainder is 0.
- Payload: 32-bit lane k of each beat carries {`pkt_idx`[15:0], `beat_idx`[12:0], k[2:0]}.
  - Lanes beyond the packet's last valid byte still carry this pattern; their `tstrb` is 0.
- `counter` wraps from 255 to 0. `pkt_idx` is 16 bits and never wraps within a run.
- `start` is ignored while `busy`. Changes to the config inputs mid-run have no effect.

## Timing
- Reset values: `tvalid`, `tlast`, `busy`, `activity_send` are 0; `counter`, `tdata`, `tstrb`, `tuser` are 0; the FSM is in IDLE.
- Latency from start: `start` is sampled at edge N; `tvalid`=1 and `busy`=1 in the cycle after edge N.
- Handshake rules:
  - Once `tvalid` is asserted, it and all payload fields are held stable until `tready`.
  - `tvalid` never depends combinationally on `tready`.
  - Every output is registered.
- Back-to-back packets with `ipg`=0: `tvalid` stays continuously high across the packet boundary when `tready`=1.
- With `ipg`=g: exactly g cycles of `tvalid`=0 between the tlast acceptance and the next first beat.
- `activity_send` and the `counter` increment are visible in the cycle after the accepting edge.
- `busy` falls in the cycle after the final tlast acceptance.
- Reset mid-packet: all outputs clear immediately (asynchronously). A partial packet is abandoned and is not resumed.

## Configuration
- Macro: `NF10_AXIS_PKT_GEN_TUSER_META_EN`.
- Defined: on the first beat of each packet, tuser[15:0] = `pkt_len` and tuser[23:16] = `C_SRC_PORT`. All other tuser bits, and tuser on all other beats, are 0.
- Undefined: tuser is constant 0.

## Structure
- Package `nf10_axis_pkt_gen_pkg`: the FSM state enum (IDLE/SEND/GAP), the BYTES constant, the lane count, and widths for beat and remainder arithmetic.
- Sub-module `nf10_axis_pkt_gen_beat`: combinational beat formatter. Inputs are `pkt_idx`, `beat_idx`, `is_last` and the remainder. Outputs are `tdata`, `tstrb` and `tuser`. Its results are registered by the parent.

## Test plan
- `pkt_len`=64, `pkt_count`=1, `ipg`=0, `tready`=1 → 2 beats, both `tstrb`=32'hFFFFFFFF, tlast on beat 1, `counter`=1, one `activity_send` pulse, `busy` low afterwards.
- `pkt_len`=33, `pkt_count`=3, `ipg`=4 → each packet has 2 beats with last `tstrb`=32'h00000001; exactly 4 idle cycles between packets; beat 1 of packet 2 has lane 0 = 32'h00020008.
- `tready` toggling pseudo-randomly, `pkt_len`=100, `pkt_count`=5 → no payload change while stalled; 20 accepted beats; `counter`=5.
- `pkt_count`=300, `pkt_len`=1 → `counter` wraps and reads 44 at completion; 300 `activity_send` pulses.
- `start` with `pkt_len`=0, then `start` while busy → the first is ignored with `busy` staying 0; the second does not alter the run.
- `aresetn` asserted mid-beat 1 of a 3-beat packet → `tvalid` is 0 immediately and `counter`=0; a fresh `start` restarts at `pkt_idx` 0. With the macro defined, the first beat's tuser[23:0] = {`C_SRC_PORT`, `pkt_len`}.
